// File: rtl/jelly2_fifo_pkg.sv
// Shared definitions for jelly2_fifo read-side masters: read latency and
// default output-buffer sizing derived from the FIFO's DOUT_REGS setting.
package jelly2_fifo_pkg;

  // Extra buffer slots beyond the read latency; one slot lets a pop and a
  // fresh read overlap so the stream sustains one word per cycle.
  localparam int READ_BUF_MARGIN = 1;

  function automatic int read_latency(input bit dout_regs);
    return dout_regs ? 2 : 1;
  endfunction

  function automatic int default_buf_size(input bit dout_regs);
    return read_latency(dout_regs) + READ_BUF_MARGIN;
  endfunction

endpackage

// File: rtl/jelly2_fifo_stream_reader_buf.sv
// Circular skid buffer for the FIFO stream reader: explicit pointer wrap for
// any depth, separate occupancy counter, data presented from registers only.
module jelly2_fifo_stream_reader_buf #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_SIZE   = 2
) (
  input  logic                  reset_n,
  input  logic                  clk,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  valid
);

  localparam int PTR_WIDTH = (BUF_SIZE > 1) ? $clog2(BUF_SIZE) : 1;
  localparam int OCC_WIDTH = $clog2(BUF_SIZE + 1);

  logic [DATA_WIDTH-1:0] mem [BUF_SIZE];
  logic [PTR_WIDTH-1:0]  wr_ptr;
  logic [PTR_WIDTH-1:0]  rd_ptr;
  logic [OCC_WIDTH-1:0]  occupancy;

  function automatic logic [PTR_WIDTH-1:0] next_ptr(input logic [PTR_WIDTH-1:0] p);
    return (p == PTR_WIDTH'(BUF_SIZE - 1)) ? '0 : p + PTR_WIDTH'(1);
  endfunction

  // NOTE: storage has no reset; occupancy gates its visibility, so stale
  // entries are never presented and the array maps to plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      occupancy <= '0;
    end else begin
      if (push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({push, pop})
        2'b10:   occupancy <= occupancy + OCC_WIDTH'(1);
        2'b01:   occupancy <= occupancy - OCC_WIDTH'(1);
        default: occupancy <= occupancy;
      endcase
    end
  end

  assign valid    = (occupancy != '0);
  assign pop_data = valid ? mem[rd_ptr] : '0;

  overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && occupancy == OCC_WIDTH'(BUF_SIZE)));

endmodule

// File: rtl/jelly2_fifo_stream_reader.sv
// Read-side master for jelly2_fifo: issues credit-limited reads, tracks words
// in flight through the FIFO read latency, and presents them as a stream.
module jelly2_fifo_stream_reader
  import jelly2_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter bit DOUT_REGS  = 1'b0,
  parameter int BUF_SIZE   = default_buf_size(DOUT_REGS),
  parameter int CNT_WIDTH  = $clog2(BUF_SIZE + 1)
) (
  input  logic                  reset_n,
  input  logic                  clk,
  input  logic                  fifo_empty,
  input  logic [DATA_WIDTH-1:0] fifo_rd_data,
  output logic                  fifo_rd_en,
  output logic                  fifo_rd_regcke,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [CNT_WIDTH-1:0]  m_buf_count
);

  localparam int LAT = read_latency(DOUT_REGS);

  if (BUF_SIZE < LAT + 1) begin : g_buf_size_check
    $error("jelly2_fifo_stream_reader: BUF_SIZE must be at least read latency + 1");
  end

  logic                 active;
  logic [LAT-1:0]       inflight;
  logic [CNT_WIDTH-1:0] buf_count;
  logic [CNT_WIDTH:0]   credit;
  logic                 pop;
  logic                 push;

  assign pop  = m_valid & m_ready;
  assign push = inflight[LAT-1];

  // buf_count already equals occupancy + in-flight reads, so the free space
  // is what remains of BUF_SIZE, plus the slot released by this cycle's pop.
  assign credit = (CNT_WIDTH + 1)'(BUF_SIZE) - {1'b0, buf_count} + {{CNT_WIDTH{1'b0}}, pop};

  assign fifo_rd_en     = active & ~fifo_empty & (credit != '0);
  assign fifo_rd_regcke = 1'b1;
  assign m_buf_count    = buf_count;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      active    <= 1'b0;
      inflight  <= '0;
      buf_count <= '0;
    end else begin
      active    <= 1'b1;
      inflight  <= (inflight << 1) | LAT'(fifo_rd_en);
      buf_count <= buf_count + CNT_WIDTH'(fifo_rd_en) - CNT_WIDTH'(pop);
    end
  end

  jelly2_fifo_stream_reader_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_SIZE   (BUF_SIZE)
  ) u_buf (
    .reset_n   (reset_n),
    .clk       (clk),
    .push      (push),
    .push_data (fifo_rd_data),
    .pop       (pop),
    .pop_data  (m_data),
    .valid     (m_valid)
  );

endmodule

// File: tb/tb_jelly2_fifo_stream_reader.sv
// Scoreboard bench: two reader instances (DOUT_REGS=0 and 1), each behind a
// 16-entry FIFO model, driven by shared write and ready stimulus.
module tb_jelly2_fifo_stream_reader;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       fifo_rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       m_ready;

  logic       rd_en_a   [2];
  logic       empty_a   [2];
  logic       full_a    [2];
  logic       m_valid_a [2];
  logic [7:0] m_data_a  [2];
  logic [3:0] count_a   [2];
  int         viol_a    [2];
  int         n_pop_a   [2];
  int         q_size_a  [2];

  int n_pass  = 0;
  int n_total = 0;

  int first_rd [2];
  int first_v  [2];
  int max_run  [2];

  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_total++;
    if (actual == expected) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, actual, expected);
  endtask

  for (genvar g = 0; g < 2; g++) begin : gen_dut
    localparam int BS = g + 2;
    localparam int CW = $clog2(BS + 1);

    logic [7:0]    mem [16];
    logic [4:0]    wptr, rptr, cnt;
    logic [7:0]    st1, st2, rd_data;
    logic          rd_en, regcke, empty, full;
    logic [7:0]    m_data;
    logic          m_valid;
    logic [CW-1:0] cnt_w;
    logic [7:0]    exp_q [$];
    int            viol  = 0;
    int            n_pop = 0;
    logic          held_v = 1'b0;
    logic [7:0]    held_d = '0;

    assign empty   = (cnt == 5'd0);
    assign full    = (cnt == 5'd16);
    assign rd_data = (g == 1) ? st2 : st1;

    always @(posedge clk) begin
      if (fifo_rst_n && wr_en && !full) mem[wptr[3:0]] <= wr_data;
    end

    always @(posedge clk or negedge fifo_rst_n) begin
      if (!fifo_rst_n) begin
        wptr <= '0; rptr <= '0; cnt <= '0; st1 <= '0; st2 <= '0;
      end else begin
        if (wr_en && !full) wptr <= wptr + 5'd1;
        if (rd_en && !empty) begin
          st1  <= mem[rptr[3:0]];
          rptr <= rptr + 5'd1;
        end
        if (regcke) st2 <= st1;
        cnt <= cnt + 5'(wr_en && !full) - 5'(rd_en && !empty);
      end
    end

    always @(posedge clk) begin
      if (fifo_rst_n && wr_en && !full) exp_q.push_back(wr_data);
    end

    always @(negedge fifo_rst_n) exp_q.delete();

    jelly2_fifo_stream_reader #(
      .DATA_WIDTH (8),
      .DOUT_REGS  (g == 1)
    ) u_dut (
      .reset_n        (reset_n),
      .clk            (clk),
      .fifo_empty     (empty),
      .fifo_rd_data   (rd_data),
      .fifo_rd_en     (rd_en),
      .fifo_rd_regcke (regcke),
      .m_data         (m_data),
      .m_valid        (m_valid),
      .m_ready        (m_ready),
      .m_buf_count    (cnt_w)
    );

    always @(negedge clk) begin
      if (!reset_n) begin
        held_v = 1'b0;
      end else begin
        if (rd_en && empty) viol++;
        if (held_v) begin
          check($sformatf("hold_valid[%0d]", g), int'(m_valid), 1);
          check($sformatf("hold_data[%0d]", g), int'(m_data), int'(held_d));
        end
        if (m_valid && m_ready) begin
          n_pop++;
          if (exp_q.size() == 0) check($sformatf("pop_unexpected[%0d]", g), int'(m_data), -1);
          else check($sformatf("pop_data[%0d]", g), int'(m_data), int'(exp_q.pop_front()));
        end
        held_v = m_valid && !m_ready;
        held_d = m_data;
      end
    end

    assign rd_en_a[g]   = rd_en;
    assign empty_a[g]   = empty;
    assign full_a[g]    = full;
    assign m_valid_a[g] = m_valid;
    assign m_data_a[g]  = m_data;
    assign count_a[g]   = 4'(cnt_w);
    assign viol_a[g]    = viol;
    assign n_pop_a[g]   = n_pop;
    assign q_size_a[g]  = exp_q.size();
  end

  task automatic write_word(input logic [7:0] d);
    @(posedge clk); #1;
    wr_en   = 1'b1;
    wr_data = d;
  endtask

  task automatic end_write();
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk); #1;
    m_ready = r;
  endtask

  task automatic sample_stream(input int cycles);
    int run [2];
    for (int g = 0; g < 2; g++) begin
      first_rd[g] = -1; first_v[g] = -1; max_run[g] = 0; run[g] = 0;
    end
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        if (rd_en_a[g] && first_rd[g] < 0) first_rd[g] = c;
        if (m_valid_a[g] && first_v[g] < 0) first_v[g] = c;
        run[g] = m_valid_a[g] ? run[g] + 1 : 0;
        if (run[g] > max_run[g]) max_run[g] = run[g];
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int  c = 0;
    bit  idle = 1'b0;
    while (c < 500 && !idle) begin
      @(negedge clk);
      c++;
      idle = 1'b1;
      for (int g = 0; g < 2; g++)
        if (m_valid_a[g] || count_a[g] != 4'd0 || !empty_a[g]) idle = 1'b0;
    end
    check({tag, "_idle_reached"}, int'(idle), 1);
    for (int g = 0; g < 2; g++)
      check($sformatf("%s_queue_drained[%0d]", tag, g), q_size_a[g], 0);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int pops_before [2];
    int written;
    int guard;

    reset_n = 1'b0; fifo_rst_n = 1'b0;
    wr_en = 1'b0; wr_data = '0; m_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 fifo_rst_n = 1'b1;

    // 1: reader held in reset while the FIFO fills
    write_word(8'h11); write_word(8'h22); write_word(8'h33); end_write();
    repeat (2) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("rst_rd_en[%0d]", g), int'(rd_en_a[g]), 0);
      check($sformatf("rst_valid[%0d]", g), int'(m_valid_a[g]), 0);
      check($sformatf("rst_count[%0d]", g), int'(count_a[g]), 0);
      check($sformatf("rst_data[%0d]", g), int'(m_data_a[g]), 0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    sample_stream(12);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("first_rd_after_release[%0d]", g), first_rd[g], 1);
      check($sformatf("release_latency[%0d]", g), first_v[g] - first_rd[g], g + 2);
    end
    wait_idle("t1");

    // 2: streaming with m_ready held high
    fork
      begin
        for (int i = 1; i <= 16; i++) write_word(8'(i));
        end_write();
      end
      sample_stream(40);
    join
    for (int g = 0; g < 2; g++) begin
      check($sformatf("stream_latency[%0d]", g), first_v[g] - first_rd[g], g + 2);
      check($sformatf("stream_run[%0d]", g), max_run[g], 16);
    end
    wait_idle("t2");

    // 3: backpressure
    set_ready(1'b0);
    for (int i = 0; i < 16; i++) write_word(8'h40 + 8'(i));
    end_write();
    repeat (10) @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("stall_count[%0d]", g), int'(count_a[g]), g + 2);
      check($sformatf("stall_valid[%0d]", g), int'(m_valid_a[g]), 1);
    end
    set_ready(1'b1);
    wait_idle("t3");

    // 4: random data and random ready
    written = 0; guard = 0;
    while (written < 1000 && guard < 20000) begin
      @(posedge clk); #1;
      guard++;
      m_ready = 1'($urandom_range(0, 1));
      if (!full_a[0] && !full_a[1]) begin
        wr_en = 1'b1; wr_data = 8'($urandom); written++;
      end else begin
        wr_en = 1'b0;
      end
    end
    check("random_words_written", written, 1000);
    end_write();
    set_ready(1'b1);
    wait_idle("t4");

    // 5: single word drain
    for (int g = 0; g < 2; g++) pops_before[g] = n_pop_a[g];
    write_word(8'hA5); end_write();
    wait_idle("t5");
    for (int g = 0; g < 2; g++) begin
      check($sformatf("drain_pops[%0d]", g), n_pop_a[g] - pops_before[g], 1);
      check($sformatf("drain_valid[%0d]", g), int'(m_valid_a[g]), 0);
      check($sformatf("drain_count[%0d]", g), int'(count_a[g]), 0);
    end

    // 6: reset with words buffered and in flight
    set_ready(1'b0);
    for (int i = 0; i < 4; i++) write_word(8'h60 + 8'(i));
    end_write();
    @(negedge clk);
    for (int g = 0; g < 2; g++)
      check($sformatf("pre_reset_count[%0d]", g), int'(count_a[g]), g + 2);
    @(posedge clk); #1 reset_n = 1'b0; fifo_rst_n = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      check($sformatf("midrst_rd_en[%0d]", g), int'(rd_en_a[g]), 0);
      check($sformatf("midrst_valid[%0d]", g), int'(m_valid_a[g]), 0);
      check($sformatf("midrst_count[%0d]", g), int'(count_a[g]), 0);
      check($sformatf("midrst_data[%0d]", g), int'(m_data_a[g]), 0);
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1; fifo_rst_n = 1'b1;
    for (int g = 0; g < 2; g++) pops_before[g] = n_pop_a[g];
    m_ready = 1'b1;
    write_word(8'h70); write_word(8'h71); end_write();
    wait_idle("t6");
    for (int g = 0; g < 2; g++)
      check($sformatf("post_reset_pops[%0d]", g), n_pop_a[g] - pops_before[g], 2);

    for (int g = 0; g < 2; g++)
      check($sformatf("rd_en_while_empty[%0d]", g), viol_a[g], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
